// File: rtl/cpu_pkg.sv
// Shared RV32I encodings and ALU operation codes, used by the operand stage and the ALU.
package cpu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
  typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_e;

  typedef struct packed {
    logic [3:0] alu_op;
    src_a_e     src_a;
    src_b_e     src_b;
    logic       illegal;
    logic       wb;
    logic       branch;
    logic       jal;
    logic       jalr;
  } dec_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
  } s1_t;

  // Register/immediate arithmetic; 'sub' only matters for funct3 000.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic sub);
    case (f3)
      F3_ADD:  arith_op = sub ? ALU_SUB : ALU_ADD;
      F3_SLL:  arith_op = ALU_SLL;
      F3_SLT:  arith_op = ALU_SLT;
      F3_SLTU: arith_op = ALU_SLTU;
      F3_XOR:  arith_op = ALU_XOR;
      F3_SRL:  arith_op = ALU_SRL;
      F3_OR:   arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7b5 into ALU op, operand selects and class flags.
module alu_op_decode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.src_a   = SRC_A_RS1;
    dec.src_b   = SRC_B_IMM;
    case (opcode)
      OPC_OP: begin
        dec.src_b   = SRC_B_RS2;
        dec.alu_op  = arith_op(funct3, funct7b5);
        dec.wb      = 1'b1;
        dec.illegal = (funct3 == F3_SRL) && funct7b5;
      end
      OPC_OP_IMM: begin
        dec.alu_op  = arith_op(funct3, 1'b0);
        dec.wb      = 1'b1;
        dec.illegal = (funct3 == F3_SRL) && funct7b5;
      end
      OPC_LOAD:  dec.wb = 1'b1;
      OPC_STORE: dec.wb = 1'b0;
      OPC_LUI: begin
        dec.src_a = SRC_A_ZERO;
        dec.wb    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.src_a = SRC_A_PC;
        dec.wb    = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.src_a = SRC_A_PC;
        dec.src_b = SRC_B_FOUR;
        dec.wb    = 1'b1;
        dec.jal   = (opcode == OPC_JAL);
        dec.jalr  = (opcode == OPC_JALR);
      end
      OPC_BRANCH: begin
        dec.src_b  = SRC_B_RS2;
        dec.branch = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE:   dec.alu_op = ALU_SUB;
          F3_BLT, F3_BGE:   dec.alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: dec.alu_op = ALU_SLTU;
          default:          dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions must never write back or redirect.
    if (dec.illegal) begin
      dec.wb     = 1'b0;
      dec.branch = 1'b0;
      dec.jal    = 1'b0;
      dec.jalr   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Two-stage operand/result pipeline around an external ALU: S1 holds operands, S2 holds writeback payload.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] alu_src_a,
  output logic [XLEN-1:0] alu_src_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target,
  output logic            out_illegal
);

  logic        s1_valid, s2_valid;
  logic        s1_adv, in_fire;
  s1_t         s1;
  dec_t        dec;
  logic        cond, taken, wb_en;
  logic [31:0] tgt_base, tgt_sum, target;

  assign s1_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (flush)        s1_valid <= 1'b0;
      else if (in_fire) s1_valid <= 1'b1;
      else if (s1_adv)  s1_valid <= 1'b0;
      if (in_fire)
        s1 <= '{opcode: in_opcode, funct3: in_funct3, funct7b5: in_funct7b5,
                rs1: in_rs1, rs2: in_rs2, imm: in_imm, pc: in_pc, rd: in_rd};
    end
  end

  alu_op_decode u_dec (
    .opcode   (s1.opcode),
    .funct3   (s1.funct3),
    .funct7b5 (s1.funct7b5),
    .dec      (dec)
  );

  // An empty S1 presents a harmless 0+0 ADD to the ALU.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = '0;
    alu_src_b = '0;
    if (s1_valid) begin
      alu_op = dec.alu_op;
      case (dec.src_a)
        SRC_A_PC:   alu_src_a = s1.pc;
        SRC_A_ZERO: alu_src_a = '0;
        default:    alu_src_a = s1.rs1;
      endcase
      case (dec.src_b)
        SRC_B_RS2:  alu_src_b = s1.rs2;
        SRC_B_FOUR: alu_src_b = 32'd4;
        default:    alu_src_b = s1.imm;
      endcase
    end
  end

  always_comb begin
    case (s1.funct3)
      F3_BEQ:           cond = alu_zero;
      F3_BNE:           cond = !alu_zero;
      F3_BLT, F3_BLTU:  cond = alu_result[0];
      F3_BGE, F3_BGEU:  cond = !alu_result[0];
      default:          cond = 1'b0;
    endcase
  end

  assign taken    = dec.branch ? cond : (dec.jal || dec.jalr);
  assign wb_en    = dec.wb && (s1.rd != 5'd0);
  assign tgt_base = dec.jalr ? s1.rs1 : s1.pc;
  assign tgt_sum  = tgt_base + s1.imm;
  assign target   = {tgt_sum[31:1], tgt_sum[0] & ~dec.jalr};

  // Payload only moves on s1_adv, so it holds while the consumer stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid      <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_wb_en     <= 1'b0;
      out_br_taken  <= 1'b0;
      out_br_target <= '0;
      out_illegal   <= 1'b0;
    end else begin
      if (flush)          s2_valid <= 1'b0;
      else if (s1_adv)    s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
      if (s1_adv && !flush) begin
        out_result    <= alu_result;
        out_rd        <= s1.rd;
        out_wb_en     <= wb_en;
        out_br_taken  <= taken;
        out_br_target <= target;
        out_illegal   <= dec.illegal;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
